// File: rtl/stepper_pkg.sv
// Shared stepper definitions: decoder FSM states, one-hot wave-drive phases
// in {A, B, /A, /B} order, and the phase-to-index mapping used on both sides.
package stepper_pkg;

    typedef enum logic [1:0] {
        NOREF = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] PHASE_0 = 4'b1000;
    localparam logic [3:0] PHASE_1 = 4'b0100;
    localparam logic [3:0] PHASE_2 = 4'b0010;
    localparam logic [3:0] PHASE_3 = 4'b0001;

    // Only meaningful for one-hot inputs; anything else maps to 0.
    function automatic logic [1:0] phase_to_index(input logic [3:0] p);
        logic [1:0] idx;
        idx = 2'd0;
        case (p)
            PHASE_0: idx = 2'd0;
            PHASE_1: idx = 2'd1;
            PHASE_2: idx = 2'd2;
            PHASE_3: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic is_one_hot(input logic [3:0] p);
        return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/phase_sync_filter.sv
// Two-flop synchroniser followed by a stability counter; a pattern held for
// FILT_CYCLES cycles that differs from the current one is accepted with a strobe.
module phase_sync_filter #(
    parameter int W           = 4,
    parameter int FILT_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] pattern,
    output logic         accept
);

    localparam logic [7:0] FILT = 8'(FILT_CYCLES);

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [7:0]   stable_cnt;

    // stable_cnt counts how many cycles sync2 has held its current value,
    // saturating at FILT; it restarts at 1 on the cycle sync2 takes a new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            stable_cnt <= 8'd0;
            pattern    <= '0;
            accept     <= 1'b0;
        end else begin
            sync1  <= din;
            sync2  <= sync1;
            accept <= 1'b0;
            if (sync1 != sync2) begin
                stable_cnt <= 8'd1;
            end else if (stable_cnt != FILT) begin
                stable_cnt <= stable_cnt + 8'd1;
            end
            if (stable_cnt == FILT && sync2 != pattern) begin
                pattern <= sync2;
                accept  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_phase_decoder.sv
// Decodes filtered wave-drive phase changes into direction-tagged steps,
// tracking signed position, per-revolution index and sticky error flags.
module step_phase_decoder
    import stepper_pkg::*;
#(
    parameter int FILT_CYCLES   = 4,
    parameter int POS_W         = 16,
    parameter int STEPS_PER_REV = 2048
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [3:0]                       phase_in,
    input  logic                             clear_err,
    output logic                             step_pulse,
    output logic                             step_dir,
    output logic signed [POS_W-1:0]          position,
    output logic [$clog2(STEPS_PER_REV)-1:0] rev_cnt,
    output logic                             rev_pulse,
    output logic                             idle,
    output logic                             err_skip,
    output logic                             err_illegal,
    output state_t                           state_dbg
);

    localparam int               REV_W   = $clog2(STEPS_PER_REV);
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(STEPS_PER_REV - 1);

    logic [3:0] acc_pat;
    logic       acc_strobe;
    state_t     state;
    logic [1:0] last_idx;
    logic [1:0] new_idx;
    logic [1:0] delta;
    logic       one_hot;

    phase_sync_filter #(
        .W           (4),
        .FILT_CYCLES (FILT_CYCLES)
    ) u_filter (
        .clk     (clk),
        .reset   (reset),
        .din     (phase_in),
        .pattern (acc_pat),
        .accept  (acc_strobe)
    );

    // delta of 1 is a forward neighbour, 3 reverse, 2 the opposite phase.
    always_comb begin
        new_idx = phase_to_index(acc_pat);
        delta   = new_idx - last_idx;
        one_hot = is_one_hot(acc_pat);
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= NOREF;
            last_idx    <= 2'd0;
            step_pulse  <= 1'b0;
            step_dir    <= 1'b0;
            position    <= '0;
            rev_cnt     <= '0;
            rev_pulse   <= 1'b0;
            idle        <= 1'b1;
            err_skip    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            rev_pulse  <= 1'b0;
            idle       <= (acc_pat == 4'd0);
            // Clear first so an error raised in the same cycle takes priority.
            if (clear_err) begin
                err_skip    <= 1'b0;
                err_illegal <= 1'b0;
            end
            if (acc_strobe) begin
                if (acc_pat == 4'd0) begin
                    if (state != NOREF) state <= HOLD;
                end else if (!one_hot) begin
                    err_illegal <= 1'b1;
                    state       <= NOREF;
                end else begin
                    state    <= TRACK;
                    last_idx <= new_idx;
                    if (state != NOREF) begin
                        case (delta)
                            2'd1: begin
                                step_pulse <= 1'b1;
                                step_dir   <= 1'b1;
                                position   <= position + POS_W'(1);
                                if (rev_cnt == REV_MAX) begin
                                    rev_cnt   <= '0;
                                    rev_pulse <= 1'b1;
                                end else begin
                                    rev_cnt <= rev_cnt + REV_W'(1);
                                end
                            end
                            2'd3: begin
                                step_pulse <= 1'b1;
                                step_dir   <= 1'b0;
                                position   <= position - POS_W'(1);
                                if (rev_cnt == '0) begin
                                    rev_cnt   <= REV_MAX;
                                    rev_pulse <= 1'b1;
                                end else begin
                                    rev_cnt <= rev_cnt - REV_W'(1);
                                end
                            end
                            2'd2:    err_skip <= 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_step_phase_decoder.sv
// Directed bench for step_phase_decoder: a table of phase holds with expected
// results, plus hand-written latency, glitch, error-clear, reset and wrap sequences.
module tb_step_phase_decoder;
    import stepper_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  phase_in;
    logic        clear_err;
    logic        step_pulse;
    logic        step_dir;
    logic signed [15:0] position;
    logic [10:0] rev_cnt;
    logic        rev_pulse;
    logic        idle;
    logic        err_skip;
    logic        err_illegal;
    state_t      state_dbg;

    step_phase_decoder #(
        .FILT_CYCLES   (4),
        .POS_W         (16),
        .STEPS_PER_REV (2048)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .phase_in    (phase_in),
        .clear_err   (clear_err),
        .step_pulse  (step_pulse),
        .step_dir    (step_dir),
        .position    (position),
        .rev_cnt     (rev_cnt),
        .rev_pulse   (rev_pulse),
        .idle        (idle),
        .err_skip    (err_skip),
        .err_illegal (err_illegal),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] phase;
        int         cyc;
        int         steps;
        logic       dir;
        int         pos;
        logic       idl;
        logic       skip;
        logic       ill;
        state_t     st;
    } vec_t;

    vec_t       tbl [0:10];
    logic [3:0] phases [0:3];

    int checks = 0;
    int errors = 0;
    int n_steps, n_fwd, n_revs, n_orphan;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        n_steps  = 0;
        n_fwd    = 0;
        n_revs   = 0;
        n_orphan = 0;
    endtask

    // driver: apply a phase pattern for n cycles, tallying output strobes
    task automatic hold(input logic [3:0] p, input int n);
        phase_in = p;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (step_pulse) begin
                n_steps++;
                if (step_dir) n_fwd++;
            end
            if (rev_pulse) begin
                n_revs++;
                if (!step_pulse) n_orphan++;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".step_pulse"}, step_pulse, 0);
        check({tag, ".step_dir"}, step_dir, 0);
        check({tag, ".position"}, position, 0);
        check({tag, ".rev_cnt"}, rev_cnt, 0);
        check({tag, ".rev_pulse"}, rev_pulse, 0);
        check({tag, ".idle"}, idle, 1);
        check({tag, ".err_skip"}, err_skip, 0);
        check({tag, ".err_illegal"}, err_illegal, 0);
        check({tag, ".state"}, int'(state_dbg), int'(NOREF));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_vec(input int i);
        clr_counts();
        hold(tbl[i].phase, tbl[i].cyc);
        check($sformatf("v%0d.steps", i), n_steps, tbl[i].steps);
        check($sformatf("v%0d.dir", i), step_dir, tbl[i].dir);
        check($sformatf("v%0d.position", i), position, tbl[i].pos);
        check($sformatf("v%0d.idle", i), idle, tbl[i].idl);
        check($sformatf("v%0d.err_skip", i), err_skip, tbl[i].skip);
        check($sformatf("v%0d.err_illegal", i), err_illegal, tbl[i].ill);
        check($sformatf("v%0d.state", i), int'(state_dbg), int'(tbl[i].st));
    endtask

    initial begin
        int rev_at;
        int prev;

        phases[0] = 4'b1000;
        phases[1] = 4'b0100;
        phases[2] = 4'b0010;
        phases[3] = 4'b0001;

        //            phase    cyc st dir pos idle skp ill state
        tbl[0]  = '{4'b1000, 20, 1, 0, 0, 0, 0, 0, TRACK};
        tbl[1]  = '{4'b0000, 20, 0, 0, 0, 1, 0, 0, HOLD};
        tbl[2]  = '{4'b0100, 20, 1, 1, 1, 0, 0, 0, TRACK};
        tbl[3]  = '{4'b1000, 20, 1, 0, 0, 0, 0, 0, TRACK};
        tbl[4]  = '{4'b0000, 20, 0, 0, 0, 1, 0, 0, HOLD};
        tbl[5]  = '{4'b1000, 20, 0, 0, 0, 0, 0, 0, TRACK};
        tbl[6]  = '{4'b0010, 20, 0, 0, 0, 0, 1, 0, TRACK};
        tbl[7]  = '{4'b0001, 20, 1, 1, 1, 0, 1, 0, TRACK};
        tbl[8]  = '{4'b1100, 20, 0, 1, 1, 0, 0, 1, NOREF};
        tbl[9]  = '{4'b0100, 20, 0, 1, 1, 0, 0, 1, TRACK};
        tbl[10] = '{4'b1000, 20, 1, 0, 0, 0, 0, 1, TRACK};

        phase_in  = 4'b0000;
        clear_err = 1'b0;
        do_reset(3);
        check_reset_values("reset");
        reset = 1'b0;

        // reference phase only, then one forward step with exact latency
        clr_counts();
        hold(4'b1000, 10);
        check("ref.steps", n_steps, 0);
        check("ref.idle", idle, 0);
        check("ref.position", position, 0);
        check("ref.state", int'(state_dbg), int'(TRACK));
        phase_in = 4'b0100;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) check("latency.early", step_pulse, 0);
            if (k == 7) check("latency.step", step_pulse, 1);
        end
        check("first.dir", step_dir, 1);
        check("first.position", position, 1);
        check("first.rev_cnt", rev_cnt, 1);
        clr_counts();
        hold(4'b0100, 13);
        check("first.single_pulse", n_steps, 0);

        run_vec(0);

        // glitches inside a steady 1000
        clr_counts();
        hold(4'b0100, 3);
        hold(4'b1000, 17);
        check("glitch3.steps", n_steps, 0);
        check("glitch3.position", position, 0);
        check("glitch3.err", {err_skip, err_illegal}, 0);
        clr_counts();
        hold(4'b0100, 4);
        hold(4'b1000, 20);
        check("glitch4.steps", n_steps, 2);
        check("glitch4.fwd", n_fwd, 1);
        check("glitch4.position", position, 0);

        for (int i = 1; i <= 7; i++) run_vec(i);

        // clear_err coincides with a fresh skip (0001 -> 0100): set wins
        clr_counts();
        hold(4'b0100, 6);
        check("skipclr.before", err_skip, 1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("skipclr.set_wins", err_skip, 1);
        hold(4'b0100, 13);
        check("skipclr.steps", n_steps, 0);
        check("skipclr.position", position, 1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("clear.err_skip", err_skip, 0);

        for (int i = 8; i <= 10; i++) run_vec(i);

        // reset in the middle of a pending transition
        clr_counts();
        hold(4'b0100, 3);
        do_reset(2);
        check_reset_values("midreset");
        reset = 1'b0;
        clr_counts();
        hold(4'b0100, 20);
        check("postreset.steps", n_steps, 0);
        check("postreset.position", position, 0);
        check("postreset.idle", idle, 0);
        clr_counts();
        hold(4'b0010, 20);
        check("postreset.fwd", n_fwd, 1);
        check("postreset.position2", position, 1);

        // full revolution forward, then four reverse steps across the wrap
        do_reset(2);
        reset = 1'b0;
        clr_counts();
        hold(4'b1000, 20);
        rev_at = -1;
        for (int i = 1; i <= 2048; i++) begin
            prev = n_revs;
            hold(phases[i % 4], 20);
            if (n_revs != prev) rev_at = i;
        end
        check("rev.steps", n_steps, 2048);
        check("rev.fwd", n_fwd, 2048);
        check("rev.position", position, 2048);
        check("rev.rev_cnt", rev_cnt, 0);
        check("rev.pulses", n_revs, 1);
        check("rev.pulse_step", rev_at, 2048);
        clr_counts();
        hold(phases[3], 20);
        check("rev_back.first_pulse", n_revs, 1);
        check("rev_back.first_cnt", rev_cnt, 2047);
        for (int j = 2; j <= 4; j++) hold(phases[(4 - j) % 4], 20);
        check("rev_back.steps", n_steps, 4);
        check("rev_back.fwd", n_fwd, 0);
        check("rev_back.pulses", n_revs, 1);
        check("rev_back.position", position, 2044);
        check("rev_back.rev_cnt", rev_cnt, 2044);
        check("rev_back.orphan", n_orphan, 0);

        // report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
